// File: rtl/gate_pkg.sv
// gate_pkg: shared FSM state encoding and beam polarity for the gate sensor decoder
package gate_pkg;
   typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLR} state_t;
   localparam logic BEAM_BROKEN = 1'b1;
endpackage

// File: rtl/gate_debounce.sv
// gate_debounce: 2-flop synchronizer followed by a stable-count filter
module gate_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic clr_n,
   input  logic din,
   output logic dout
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic diff;
   assign diff = sync[1] != dout;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         sync <= '0;
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         cnt  <= (!diff || cnt == CLAST) ? '0 : cnt + CW'(1);
         dout <= (diff && cnt == CLAST) ? sync[1] : dout;
      end
endmodule

// File: rtl/gate_sensor_decoder.sv
// gate_sensor_decoder: debounced two-beam direction FSM emitting ent/ext/err pulses
module gate_sensor_decoder
   import gate_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic clk,
   input  logic clr_n,
   input  logic sens_a,
   input  logic sens_b,
   output logic ent,
   output logic ext,
   output logic busy,
   output logic err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
   logic da, db, a, b, o, tmo, ent_n, ext_n, err_n;
   logic [1:0] xy;
   logic [TW-1:0] dwell;
   state_t state, nxt, s1, s2, s3;
   gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (.clk(clk), .clr_n(clr_n), .din(sens_a), .dout(da));
   gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (.clk(clk), .clr_n(clr_n), .din(sens_b), .dout(db));
   assign a = da == BEAM_BROKEN;
   assign b = db == BEAM_BROKEN;
   // OUT states reuse the IN transition table with the beams swapped
   assign o   = state inside {OUT1, OUT2, OUT3};
   assign xy  = o ? {b, a} : {a, b};
   assign s1  = o ? OUT1 : IN1;
   assign s2  = o ? OUT2 : IN2;
   assign s3  = o ? OUT3 : IN3;
   assign tmo = !(state inside {IDLE, WAIT_CLR}) && dwell == TLAST;
   always_comb begin
      nxt   = state;
      ent_n = 1'b0;
      ext_n = 1'b0;
      err_n = 1'b0;
      case (state)
         IDLE: begin
            nxt   = (a && b) ? WAIT_CLR : a ? IN1 : b ? OUT1 : IDLE;
            err_n = a && b;
         end
         IN1, OUT1: begin
            nxt   = xy == 2'b11 ? s2 : xy == 2'b00 ? IDLE : xy == 2'b01 ? WAIT_CLR : state;
            err_n = xy == 2'b01;
         end
         IN2, OUT2: begin
            nxt   = xy == 2'b01 ? s3 : xy == 2'b10 ? s1 : xy == 2'b00 ? IDLE : state;
            err_n = xy == 2'b00;
         end
         IN3, OUT3: begin
            nxt   = xy == 2'b00 ? IDLE : xy == 2'b11 ? s2 : xy == 2'b10 ? WAIT_CLR : state;
            err_n = xy == 2'b10;
            ent_n = !o && xy == 2'b00;
            ext_n = o && xy == 2'b00;
         end
         default: nxt = (!a && !b) ? IDLE : WAIT_CLR;
      endcase
      if (tmo) begin
         nxt   = WAIT_CLR;
         err_n = 1'b1;
         ent_n = 1'b0;
         ext_n = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         state <= IDLE;
         dwell <= '0;
         ent   <= 1'b0;
         ext   <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= nxt;
         dwell <= (nxt != state || state inside {IDLE, WAIT_CLR}) ? '0 : dwell + TW'(1);
         ent   <= ent_n;
         ext   <= ext_n;
         err   <= err_n;
         busy  <= nxt != IDLE;
      end
endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb_gate_sensor_decoder: table-driven and directed checks of the gate sensor decoder
module tb_gate_sensor_decoder;
   typedef struct {
      int sa;
      int sb;
      int n_ent;
      int n_ext;
      int n_err;
      int busy;
   } vec_t;
   localparam int NV = 32;
   localparam int HOLD = 12;
   logic clk = 1'b0, clr_n = 1'b0, sens_a = 1'b0, sens_b = 1'b0;
   logic ent, ext, busy, err;
   logic ent_q = 1'b0, ext_q = 1'b0, err_q = 1'b0;
   int tests = 0, fails = 0;
   int n_ent = 0, n_ext = 0, n_err = 0, n_busy = 0, viol = 0;
   int e0, x0, r0, b0, t;
   vec_t v [NV];

   gate_sensor_decoder #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .clr_n(clr_n), .sens_a(sens_a), .sens_b(sens_b),
      .ent(ent), .ext(ext), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // pulse bookkeeping sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      n_ent  <= n_ent + int'(ent);
      n_ext  <= n_ext + int'(ext);
      n_err  <= n_err + int'(err);
      n_busy <= n_busy + int'(busy);
      if ((ent && ext) || (err && (ent || ext)) || (ent && ent_q) || (ext && ext_q) || (err && err_q))
         viol <= viol + 1;
      ent_q <= ent;
      ext_q <= ext;
      err_q <= err;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic snap();
      e0 = n_ent;
      x0 = n_ext;
      r0 = n_err;
      b0 = n_busy;
   endtask

   // cycles until the selected output (0 ent, 1 ext, 2 err, 3 busy) is first seen high, -1 if never
   task automatic first_high(input int which, input int lim, output int at);
      at = -1;
      for (int i = 1; i <= lim; i++) begin
         step(1);
         if ((which == 0 && ent) || (which == 1 && ext) || (which == 2 && err) || (which == 3 && busy)) begin
            at = i;
            return;
         end
      end
   endtask

   initial begin
      v = '{
         '{1, 0, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1}, '{0, 1, 0, 0, 0, 1}, '{0, 0, 1, 0, 0, 0},
         '{0, 1, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1}, '{1, 0, 0, 0, 0, 1}, '{0, 0, 0, 1, 0, 0},
         '{1, 0, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1}, '{1, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0},
         '{1, 1, 0, 0, 1, 1}, '{0, 1, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0},
         '{1, 0, 0, 0, 0, 1}, '{0, 1, 0, 0, 1, 1}, '{0, 0, 0, 0, 0, 0},
         '{0, 1, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1}, '{0, 0, 0, 0, 1, 0},
         '{1, 0, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1}, '{0, 1, 0, 0, 0, 1}, '{1, 0, 0, 0, 1, 1},
         '{0, 0, 0, 0, 0, 0},
         '{1, 0, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1}, '{0, 1, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1},
         '{0, 1, 0, 0, 0, 1}, '{0, 0, 1, 0, 0, 0}
      };
      // reset holds everything low even with a beam broken
      sens_a = 1'b1;
      step(8);
      chk("reset outputs", int'({ent, ext, err, busy}), 0);
      sens_a = 1'b0;
      step(HOLD);
      clr_n = 1'b1;
      step(HOLD);
      chk("idle after reset", int'({ent, ext, err, busy}), 0);

      for (int i = 0; i < NV; i++) begin
         snap();
         sens_a = v[i].sa != 0;
         sens_b = v[i].sb != 0;
         step(HOLD);
         chk($sformatf("vec%0d ent", i), n_ent - e0, v[i].n_ent);
         chk($sformatf("vec%0d ext", i), n_ext - x0, v[i].n_ext);
         chk($sformatf("vec%0d err", i), n_err - r0, v[i].n_err);
         chk($sformatf("vec%0d busy", i), int'(busy), v[i].busy);
      end

      // clean entry with exact latencies
      snap();
      sens_a = 1'b1;
      first_high(3, 20, t);
      chk("entry busy latency", t, 7);
      step(20);
      sens_b = 1'b1;
      step(20);
      sens_a = 1'b0;
      step(20);
      sens_b = 1'b0;
      first_high(0, 20, t);
      chk("entry ent latency", t, 7);
      step(1);
      chk("entry ent width", int'(ent), 0);
      step(HOLD);
      chk("entry counts", (n_ent - e0) * 100 + (n_ext - x0) * 10 + (n_err - r0), 100);
      chk("entry busy end", int'(busy), 0);

      // clean exit
      snap();
      sens_b = 1'b1;
      step(20);
      sens_a = 1'b1;
      step(20);
      sens_b = 1'b0;
      step(20);
      sens_a = 1'b0;
      first_high(1, 20, t);
      chk("exit ext latency", t, 7);
      step(HOLD);
      chk("exit counts", (n_ent - e0) * 100 + (n_ext - x0) * 10 + (n_err - r0), 10);

      // glitch rejection: 3 cycles ignored, 4 cycles enters IN1 and aborts silently
      snap();
      sens_a = 1'b1;
      step(3);
      sens_a = 1'b0;
      step(20);
      chk("glitch3 busy cycles", n_busy - b0, 0);
      snap();
      sens_a = 1'b1;
      step(4);
      sens_a = 1'b0;
      step(20);
      chk("glitch4 busy cycles", n_busy - b0, 4);
      chk("glitch4 pulses", (n_ent - e0) + (n_ext - x0) + (n_err - r0), 0);

      // timeout after 1000 cycles in IN1
      snap();
      sens_a = 1'b1;
      first_high(2, 1100, t);
      chk("timeout err latency", t, 1007);
      chk("timeout busy", int'(busy), 1);
      step(1);
      chk("timeout err width", int'(err), 0);
      step(20);
      chk("wait_clr holds", int'(busy), 1);
      sens_a = 1'b0;
      step(HOLD);
      chk("timeout release busy", int'(busy), 0);
      chk("timeout counts", (n_ent - e0) * 100 + (n_ext - x0) * 10 + (n_err - r0), 1);

      // reset while in IN2: the partial crossing is never counted
      sens_a = 1'b1;
      step(HOLD);
      sens_b = 1'b1;
      step(HOLD);
      chk("pre-reset busy", int'(busy), 1);
      snap();
      clr_n = 1'b0;
      #1;
      chk("async reset outputs", int'({ent, ext, err, busy}), 0);
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      sens_a = 1'b0;
      step(HOLD);
      chk("post-reset busy", int'(busy), 1);
      sens_b = 1'b0;
      step(HOLD);
      chk("post-reset counts", (n_ent - e0) * 100 + (n_ext - x0) * 10 + (n_err - r0), 0);
      chk("post-reset idle", int'(busy), 0);

      step(2);
      chk("pulse exclusivity/width", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
